// File: rtl/parallel_to_serial.sv
// MRAM read sequencer: issues an active-low read cycle, captures the parallel word,
// then streams it out LSB first with a valid flag and a closing done pulse.
module parallel_to_serial #(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned READ_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] mram_data,
    output logic [ADDR_W-1:0] addr_out,
    output logic              chip_en,
    output logic              write_en,
    output logic              out_en,
    output logic              lower_byte_en,
    output logic              upper_byte_en,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BIT_CNT_W  = $clog2(DATA_W + 1);
    localparam int unsigned WAIT_CNT_W = $clog2(READ_WAIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  chip_en_q, chip_en_d;
    logic                  write_en_q, write_en_d;
    logic                  out_en_q, out_en_d;
    logic                  lower_byte_en_q, lower_byte_en_d;
    logic                  upper_byte_en_q, upper_byte_en_d;
    logic                  ser_out_q, ser_out_d;
    logic                  ser_valid_q, ser_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  mram_access;

    // Next state and datapath; outputs are derived from the state being entered
    // so that each registered output lines up with its state.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    addr_d  = addr_in;
                end
            end
            ST_SETUP: begin
                state_d    = ST_WAIT;
                wait_cnt_d = '0;
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_CNT_W'(READ_WAIT - 1)) begin
                    state_d    = ST_SHIFT;
                    shift_d    = mram_data;
                    bit_cnt_d  = '0;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
                    state_d   = ST_DONE;
                    bit_cnt_d = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mram_access     = (state_d == ST_SETUP) || (state_d == ST_WAIT);
        chip_en_d       = ~mram_access;
        out_en_d        = ~mram_access;
        lower_byte_en_d = ~mram_access;
        upper_byte_en_d = ~mram_access;
        write_en_d      = 1'b1;
        ser_valid_d     = (state_d == ST_SHIFT);
        ser_out_d       = (state_d == ST_SHIFT) ? shift_d[0] : 1'b0;
        busy_d          = (state_d != ST_IDLE);
        done_d          = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            wait_cnt_q      <= '0;
            chip_en_q       <= 1'b1;
            write_en_q      <= 1'b1;
            out_en_q        <= 1'b1;
            lower_byte_en_q <= 1'b1;
            upper_byte_en_q <= 1'b1;
            ser_out_q       <= 1'b0;
            ser_valid_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            shift_q         <= shift_d;
            bit_cnt_q       <= bit_cnt_d;
            wait_cnt_q      <= wait_cnt_d;
            chip_en_q       <= chip_en_d;
            write_en_q      <= write_en_d;
            out_en_q        <= out_en_d;
            lower_byte_en_q <= lower_byte_en_d;
            upper_byte_en_q <= upper_byte_en_d;
            ser_out_q       <= ser_out_d;
            ser_valid_q     <= ser_valid_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign addr_out      = addr_q;
    assign chip_en       = chip_en_q;
    assign write_en      = write_en_q;
    assign out_en        = out_en_q;
    assign lower_byte_en = lower_byte_en_q;
    assign upper_byte_en = upper_byte_en_q;
    assign ser_out       = ser_out_q;
    assign ser_valid     = ser_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial: reset values, frame timing, busy-ignore,
// capture isolation, mid-frame reset and back-to-back frames.
module tb_parallel_to_serial;

    localparam int unsigned ADDR_W    = 20;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned READ_WAIT = 2;
    localparam int FIRST_BIT = 2 + READ_WAIT;
    localparam int LAST_BIT  = 1 + READ_WAIT + DATA_W;
    localparam int DONE_CYC  = 2 + READ_WAIT + DATA_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] mram_data;
    logic [ADDR_W-1:0] addr_out;
    logic              chip_en, write_en, out_en, lower_byte_en, upper_byte_en;
    logic              ser_out, ser_valid, busy, done;

    int total;
    int bad;
    int done_cnt;
    logic [DATA_W-1:0] got_bits;

    parallel_to_serial #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .READ_WAIT(READ_WAIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .addr_in      (addr_in),
        .mram_data    (mram_data),
        .addr_out     (addr_out),
        .chip_en      (chip_en),
        .write_en     (write_en),
        .out_en       (out_en),
        .lower_byte_en(lower_byte_en),
        .upper_byte_en(upper_byte_en),
        .ser_out      (ser_out),
        .ser_valid    (ser_valid),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " addr"}, 32'(addr_out), 32'h0);
        chk({tag, " ctrl"}, 32'({chip_en, write_en, out_en, lower_byte_en, upper_byte_en}), 32'h1f);
        chk({tag, " ser"}, 32'({ser_out, ser_valid}), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
        chk({tag, " done"}, 32'(done), 32'h0);
    endtask

    // Expected outputs c cycles after the accepting edge of a frame.
    task automatic check_cycle(input int c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic in_bits;
        logic exp_ser;
        in_bits = (c >= FIRST_BIT) && (c <= LAST_BIT);
        exp_ser = in_bits ? d[c - FIRST_BIT] : 1'b0;
        chk($sformatf("c%0d addr", c), 32'(addr_out), 32'(a));
        chk($sformatf("c%0d busy", c), 32'(busy), 32'(c <= DONE_CYC));
        chk($sformatf("c%0d ctrl", c),
            32'({chip_en, write_en, out_en, lower_byte_en, upper_byte_en}),
            (c >= 1 && c <= 1 + READ_WAIT) ? 32'h08 : 32'h1f);
        chk($sformatf("c%0d valid", c), 32'(ser_valid), 32'(in_bits));
        chk($sformatf("c%0d ser", c), 32'(ser_out), 32'(exp_ser));
        chk($sformatf("c%0d done", c), 32'(done), 32'(c == DONE_CYC));
        if (done) done_cnt++;
        if (ser_valid) got_bits = {ser_out, got_bits[DATA_W-1:1]};
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        start     = 1'b0;
        addr_in   = '0;
        mram_data = '0;

        // Asynchronous reset with arbitrary inputs, before any clock edge.
        #1;
        addr_in   = ADDR_W'($urandom);
        mram_data = DATA_W'($urandom);
        start     = 1'b1;
        rst       = 1'b0;
        #1;
        check_reset("por");

        // Single read with a busy-time start and mram_data change after capture.
        @(negedge clk);
        rst       = 1'b1;
        start     = 1'b1;
        addr_in   = 20'h0A5C3;
        mram_data = 16'hB6E1;
        done_cnt  = 0;
        got_bits  = '0;
        for (int c = 1; c <= DONE_CYC + 1; c++) begin
            @(negedge clk);
            check_cycle(c, 20'h0A5C3, 16'hB6E1);
            start = 1'b0;
            if (c == 5) mram_data = 16'h0000;
            if (c == 8) begin
                start   = 1'b1;
                addr_in = 20'hFFFFF;
            end
        end
        chk("frame1 bits", 32'(got_bits), 32'h0000B6E1);
        chk("frame1 done count", 32'(done_cnt), 32'd1);

        // Reset in cycle 10 of a frame.
        start     = 1'b1;
        addr_in   = 20'h12345;
        mram_data = 16'h5A5A;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check_cycle(c, 20'h12345, 16'h5A5A);
            start = 1'b0;
        end
        #1;
        rst = 1'b0;
        #1;
        check_reset("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset($sformatf("inrst%0d", i));
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset($sformatf("postrst%0d", i));
        end

        // Fresh frame after the aborted one.
        start     = 1'b1;
        addr_in   = 20'h00777;
        mram_data = 16'h3C96;
        done_cnt  = 0;
        got_bits  = '0;
        for (int c = 1; c <= DONE_CYC + 1; c++) begin
            @(negedge clk);
            check_cycle(c, 20'h00777, 16'h3C96);
            start = 1'b0;
        end
        chk("frame2 bits", 32'(got_bits), 32'h00003C96);
        chk("frame2 done count", 32'(done_cnt), 32'd1);

        // Back-to-back with start held high: second frame starts after the IDLE cycle.
        start     = 1'b1;
        addr_in   = 20'h54321;
        mram_data = 16'hFFFF;
        done_cnt  = 0;
        got_bits  = '0;
        for (int c = 1; c <= 2 * (DONE_CYC + 1); c++) begin
            @(negedge clk);
            if (c <= DONE_CYC + 1) begin
                check_cycle(c, 20'h54321, 16'hFFFF);
                if (c == DONE_CYC + 1) chk("b2b frame a bits", 32'(got_bits), 32'h0000FFFF);
            end else begin
                check_cycle(c - (DONE_CYC + 1), 20'h00ABC, 16'h0001);
            end
            if (c == 10) begin
                mram_data = 16'h0001;
                addr_in   = 20'h00ABC;
            end
        end
        start = 1'b0;
        chk("b2b frame b bits", 32'(got_bits), 32'h00000001);
        chk("b2b done count", 32'(done_cnt), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
